// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ROM download path: session states and buffered byte entries.
package jtframe_dwnld_pkg;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 8;
    localparam logic [ADDR_W-1:0] CNT_MAX = 22'h3F_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/jtframe_fifo_sync.sv
// Register-based synchronous FIFO; pushes into a full FIFO are dropped even when a pop coincides.
module jtframe_fifo_sync
    import jtframe_dwnld_pkg::*;
#(
    parameter int unsigned AW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  fifo_entry_t i_din,
    input  logic        i_pop,
    output fifo_entry_t o_head,
    output logic        o_empty,
    output logic        o_full
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    fifo_entry_t     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/jtframe_dwnld.sv
// Buffers ioctl ROM bytes and replays them as masked byte writes to the SDRAM programming port.
module jtframe_dwnld
    import jtframe_dwnld_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2,
    parameter logic        SWAB    = 1'b0,
    parameter logic [21:0] ROM_END = 22'h3F_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        dwnld_done,
    output logic        overflow,
    output logic [21:0] byte_cnt
);

    state_e      r_state;
    logic        r_dl_q;
    logic        r_done;
    logic        r_overflow;
    logic [21:0] r_byte_cnt;

    logic        w_rise;
    logic        w_in_range;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_lane;
    fifo_entry_t w_din;
    fifo_entry_t w_head;

    assign w_rise     = downloading & ~r_dl_q;
    assign w_in_range = 23'(ioctl_addr) <= 23'(ROM_END);
    assign w_accept   = ioctl_wr & (r_state == LOAD) & w_in_range;
    assign w_push     = w_accept & ~w_full;
    assign w_pop      = ~w_empty & prog_rdy;
    assign w_din      = '{addr: ioctl_addr, data: ioctl_data};

    jtframe_fifo_sync #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Head-of-queue mapping onto the 16-bit SDRAM word; idle port shows all lanes masked.
    assign w_lane     = w_head.addr[0] ^ SWAB;
    assign prog_we    = ~w_empty;
    assign prog_addr  = w_empty ? '0 : {1'b0, w_head.addr[21:1]};
    assign prog_data  = w_empty ? '0 : w_head.data;
    assign prog_mask  = w_empty ? 2'b11 : (w_lane ? 2'b01 : 2'b10);

    assign dwnld_done = r_done;
    assign overflow   = r_overflow;
    assign byte_cnt   = r_byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dl_q     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            r_dl_q <= downloading;
            r_done <= 1'b0;
            if (w_push && (r_byte_cnt != CNT_MAX)) r_byte_cnt <= r_byte_cnt + 22'd1;
            if (w_accept && w_full)                r_overflow <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state    <= LOAD;
                        r_byte_cnt <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!downloading) r_state <= DRAIN;
                end
                DRAIN: begin
                    // A restarted session keeps whatever is still queued.
                    if (w_rise) begin
                        r_state    <= LOAD;
                        r_byte_cnt <= '0;
                        r_overflow <= 1'b0;
                    end else if (w_empty) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_dwnld.sv
// Bench for jtframe_dwnld: two instances (default, and SWAB=1 with a 64 KiB ROM) against a queue model.
module tb_jtframe_dwnld;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        prog_rdy;

    logic [21:0] pa   [2];
    logic [7:0]  pd   [2];
    logic [1:0]  pm   [2];
    logic        pwe  [2];
    logic        done [2];
    logic        ovf  [2];
    logic [21:0] cnt  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jtframe_dwnld dut0 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(pa[0]), .prog_data(pd[0]), .prog_mask(pm[0]), .prog_we(pwe[0]),
        .prog_rdy(prog_rdy), .dwnld_done(done[0]), .overflow(ovf[0]), .byte_cnt(cnt[0])
    );

    jtframe_dwnld #(.SWAB(1'b1), .ROM_END(22'h00_FFFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(pa[1]), .prog_data(pd[1]), .prog_mask(pm[1]), .prog_we(pwe[1]),
        .prog_rdy(prog_rdy), .dwnld_done(done[1]), .overflow(ovf[1]), .byte_cnt(cnt[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic swab_of(input int k);
        return (k == 1);
    endfunction

    function automatic logic [21:0] rom_of(input int k);
        return (k == 1) ? 22'h00_FFFF : 22'h3F_FFFF;
    endfunction

    // Model: session mode 0=idle 1=loading 2=draining, plus a 4-deep byte queue of {addr,data}.
    int          m_mode [2];
    logic [29:0] m_q    [2][4];
    int          m_n    [2];
    int          m_cnt  [2];
    bit          m_ovf  [2];
    bit          m_done [2];
    bit          m_prev_dl;

    always @(posedge clk) begin : model
        bit rise;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = 0; m_n[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
            end
            m_prev_dl = 0;
        end else begin
            rise = downloading && !m_prev_dl;
            for (int k = 0; k < 2; k++) begin
                bit was_empty, full, want, pop;
                was_empty = (m_n[k] == 0);
                full      = (m_n[k] == 4);
                want      = (m_mode[k] == 1) && ioctl_wr && (ioctl_addr <= rom_of(k));
                pop       = !was_empty && prog_rdy;
                m_done[k] = 0;
                if (want && full) m_ovf[k] = 1;
                if (pop) begin
                    for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
                    m_n[k]--;
                end
                if (want && !full) begin
                    m_q[k][m_n[k]] = {ioctl_addr, ioctl_data};
                    m_n[k]++;
                    if (m_cnt[k] < 32'h3F_FFFF) m_cnt[k]++;
                end
                case (m_mode[k])
                    0: if (rise) begin m_mode[k] = 1; m_cnt[k] = 0; m_ovf[k] = 0; end
                    1: if (!downloading) m_mode[k] = 2;
                    default: begin
                        if (rise) begin m_mode[k] = 1; m_cnt[k] = 0; m_ovf[k] = 0; end
                        else if (was_empty) begin m_mode[k] = 0; m_done[k] = 1; end
                    end
                endcase
            end
            m_prev_dl = downloading;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [29:0] h;
            logic        lane;
            h    = m_q[k][0];
            lane = h[8] ^ swab_of(k);
            chk("we",   k, 32'(pwe[k]),  32'(m_n[k] > 0));
            chk("addr", k, 32'(pa[k]),   (m_n[k] > 0) ? 32'({1'b0, h[29:9]}) : 32'd0);
            chk("data", k, 32'(pd[k]),   (m_n[k] > 0) ? 32'(h[7:0]) : 32'd0);
            chk("mask", k, 32'(pm[k]),   (m_n[k] > 0) ? (lane ? 32'd1 : 32'd2) : 32'd3);
            chk("done", k, 32'(done[k]), 32'(m_done[k]));
            chk("ovf",  k, 32'(ovf[k]),  32'(m_ovf[k]));
            chk("cnt",  k, 32'(cnt[k]),  32'(m_cnt[k]));
        end
    end

    task automatic put(input logic [21:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_data = '0; prog_rdy = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_we", k, 32'(pwe[k]), 32'd0);
            chk("rst_mask", k, 32'(pm[k]), 32'd3);
            chk("rst_cnt", k, 32'(cnt[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte at an odd address
        downloading = 1'b1; prog_rdy = 1'b1;
        @(negedge clk);
        put(22'h000005, 8'hA5);
        chk("t1_we",   0, 32'(pwe[0]), 32'd1);
        chk("t1_addr", 0, 32'(pa[0]),  32'h2);
        chk("t1_mask", 0, 32'(pm[0]),  32'h1);
        chk("t1_data", 0, 32'(pd[0]),  32'hA5);
        chk("t1_cnt",  0, 32'(cnt[0]), 32'd1);
        chk("t1_mask", 1, 32'(pm[1]),  32'h2);
        downloading = 1'b0;
        repeat (6) @(negedge clk);

        // Backpressure: five bytes into a four-deep buffer, then release
        downloading = 1'b1; prog_rdy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) put(22'(16 + i), 8'(17 + i));
        chk("t2_cnt", 0, 32'(cnt[0]), 32'd4);
        chk("t2_ovf", 0, 32'(ovf[0]), 32'd1);
        prog_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_we",   0, 32'(pwe[0]), 32'd1);
            chk("t2_data", 0, 32'(pd[0]),  32'(17 + i));
            chk("t2_addr", 0, 32'(pa[0]),  32'((16 + i) >> 1));
            @(negedge clk);
        end
        chk("t2_drained", 0, 32'(pwe[0]), 32'd0);

        // End of session with bytes still queued
        prog_rdy = 1'b0;
        for (int i = 0; i < 3; i++) put(22'(32 + i), 8'(48 + i));
        downloading = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_nodone", 0, 32'(done[0]), 32'd0);
        end
        prog_rdy = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(done[0]);
        end
        chk("t3_pulses", 0, 32'(pulses), 32'd1);

        // Out-of-range and boundary addresses on the 64 KiB instance
        downloading = 1'b1;
        @(negedge clk);
        put(22'h010000, 8'h5A);
        chk("t4_we",  1, 32'(pwe[1]), 32'd0);
        chk("t4_cnt", 1, 32'(cnt[1]), 32'd0);
        chk("t4_ovf", 1, 32'(ovf[1]), 32'd0);
        chk("t4_we",  0, 32'(pwe[0]), 32'd1);
        put(22'h00FFFF, 8'h3C);
        chk("t4_bcnt",  1, 32'(cnt[1]), 32'd1);
        chk("t4_baddr", 1, 32'(pa[1]),  32'h7FFF);
        chk("t4_bmask", 1, 32'(pm[1]),  32'h2);
        @(negedge clk);

        // Lane swap, then reset with bytes queued
        prog_rdy = 1'b0;
        put(22'h000004, 8'h44);
        chk("t5_mask", 1, 32'(pm[1]), 32'h1);
        chk("t5_mask", 0, 32'(pm[0]), 32'h2);
        put(22'h000006, 8'h66);
        rst_n = 1'b0; downloading = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t5_rst_we",   k, 32'(pwe[k]), 32'd0);
            chk("t5_rst_mask", k, 32'(pm[k]),  32'd3);
            chk("t5_rst_cnt",  k, 32'(cnt[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(done[0]) + int'(done[1]);
        end
        chk("t5_nodone", 0, 32'(pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_dwnld.md
JTFRAME_DWNLD -- requirements
Module: jtframe_dwnld

Interface
REQ-001 Parameter: FIFO_AW, default 2, log2 of buffer depth (4 entries).
REQ-002 Parameter: SWAB, default 1'b0, swaps byte lane selection when 1.
REQ-003 Parameter: ROM_END, default 22'h3F_FFFF, last valid byte address; writes above are dropped.
REQ-004 clk  in  1  system clock; only clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 downloading  in  1  download session active (from hps_io).
REQ-007 ioctl_addr  in  22  byte address of incoming ROM byte.
REQ-008 ioctl_data  in  8  incoming ROM byte.
REQ-009 ioctl_wr  in  1  one-cycle strobe: ioctl_addr/ioctl_data valid.
REQ-010 prog_addr  out  22  SDRAM 16-bit word address.
REQ-011 prog_data  out  8  byte to write.
REQ-012 prog_mask  out  2  active-low byte-lane mask (1 = lane not written).
REQ-013 prog_we  out  1  write request, held until accepted.
REQ-014 prog_rdy  in  1  SDRAM controller accepts the current write this cycle.
REQ-015 dwnld_done  out  1  one-cycle pulse at end of session.
REQ-016 overflow  out  1  sticky: a byte arrived while buffer full.
REQ-017 byte_cnt  out  22  bytes accepted into buffer this session.

Function
REQ-018 Each ioctl_wr with ioctl_addr <= ROM_END and buffer not full SHALL push {addr, data} into the FIFO on that clk edge.
REQ-019 ioctl_wr with ioctl_addr > ROM_END SHALL be discarded without push, count or overflow.
REQ-020 ioctl_wr with buffer full SHALL be discarded and set overflow; overflow clears only on reset or rising edge of downloading.
REQ-021 Head-of-FIFO mapping: prog_addr = {1'b0, addr[21:1]}; prog_data = data; lane = addr[0] ^ SWAB; prog_mask = lane ? 2'b01 : 2'b10.
REQ-022 prog_we SHALL be 1 whenever FIFO non-empty; prog_addr/prog_data/prog_mask SHALL stay stable while prog_we=1 and prog_rdy=0.
REQ-023 prog_we & prog_rdy SHALL pop the head on that edge; next entry presented next cycle (zero bubble).
REQ-024 Simultaneous push and pop SHALL keep occupancy unchanged; push to full FIFO is rejected even if pop occurs same cycle.
REQ-025 Push latency: byte written on edge N SHALL appear on prog_* after edge N when FIFO was empty (prog_we=1 in cycle N+1).
REQ-026 FSM states IDLE, LOAD, DRAIN. IDLE->LOAD on downloading rising edge (clears byte_cnt, overflow). LOAD->DRAIN on downloading=0. DRAIN->IDLE when FIFO empty, asserting dwnld_done for exactly one cycle on that transition.
REQ-027 If downloading reasserts during DRAIN, state SHALL go to LOAD without dwnld_done and without clearing the FIFO; byte_cnt and overflow clear.
REQ-028 ioctl_wr in IDLE SHALL be ignored.
REQ-029 byte_cnt SHALL increment by 1 per accepted push and saturate at 22'h3F_FFFF.
REQ-030 prog_rdy while prog_we=0 SHALL have no effect.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, FIFO empty, prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, dwnld_done=0, overflow=0, byte_cnt=0.
REQ-032 Reset mid-session SHALL discard buffered bytes; no dwnld_done pulse follows.

Structure
REQ-033 Package jtframe_dwnld_pkg holds state enum (IDLE, LOAD, DRAIN) and FIFO entry typedef {addr[21:0], data[7:0]}.
REQ-034 FIFO SHALL be a sub-module jtframe_fifo_sync (register-based, FIFO_AW parameter, full/empty flags); FSM, mapping and counters live in jtframe_dwnld.

Verification
REQ-035 Single byte: downloading=1, ioctl_wr addr=22'h000005 data=8'hA5, prog_rdy=1 -> next cycle prog_we=1, prog_addr=22'h000002, prog_mask=2'b01, prog_data=8'hA5; byte_cnt=1.
REQ-036 Backpressure: prog_rdy=0, push 5 bytes back-to-back -> 4 buffered, overflow=1, byte_cnt=4; release prog_rdy -> 4 writes in order, consecutive cycles.
REQ-037 End of session: 3 bytes buffered, prog_rdy=0, downloading falls -> no dwnld_done; prog_rdy=1 -> exactly one dwnld_done pulse the cycle FIFO empties.
REQ-038 Out of range: ROM_END=22'h00FFFF, write addr 22'h010000 -> no prog_we, byte_cnt unchanged, overflow=0.
REQ-039 SWAB=1, addr=22'h000004 -> prog_mask=2'b01; reset asserted with 2 bytes queued -> prog_we=0, prog_mask=2'b11 immediately, no dwnld_done afterwards.
